// File: rtl/mem_bus_ctrl_if.sv
// CPU/memory bus bundle for mem_bus_ctrl.
// The slave modport is the controller; the master modport is the CPU plus memory side.
interface mem_bus_ctrl_if #(
    parameter int unsigned BITS_DATA = 32,
    parameter int unsigned BITS_ADDR = 16
);
    logic                 cpu_req;
    logic                 cpu_write;
    logic [BITS_ADDR-1:0] cpu_addr;
    logic [BITS_DATA-1:0] cpu_wdata;
    logic                 cpu_ack;
    logic [BITS_DATA-1:0] cpu_rdata;
    logic                 wbuf_full;
    logic                 wbuf_empty;
    logic                 mem_en;
    logic                 mem_we;
    logic [BITS_ADDR-1:0] mem_addr;
    logic [BITS_DATA-1:0] mem_wdata;
    logic [BITS_DATA-1:0] mem_rdata;
    logic                 mem_ready;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_ack, cpu_rdata, wbuf_full, wbuf_empty,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_ack, cpu_rdata, wbuf_full, wbuf_empty,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: CPU req/ack front end, posted-write FIFO drained in order to memory.
// Define MEM_BUS_STORE_FWD_EN to forward buffered store data to reads instead of draining first.
module mem_bus_ctrl #(
    parameter int unsigned BITS_DATA  = 32,
    parameter int unsigned BITS_ADDR  = 16,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    mem_bus_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [BITS_ADDR-1:0] addr;
        logic [BITS_DATA-1:0] data;
    } wbuf_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_READ_CHK,
        ST_READ_MEM,
        ST_ACK
    } state_e;

    state_e               state_q;
    wbuf_entry_t          wbuf_q [WBUF_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d, head_nxt;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 cpu_ack_q;
    logic [BITS_DATA-1:0] cpu_rdata_q;
    logic                 mem_en_q, mem_we_q;
    logic [BITS_ADDR-1:0] mem_addr_q;
    logic [BITS_DATA-1:0] mem_wdata_q;
    logic                 wbuf_full_q, wbuf_empty_q;

    logic wr_req_c, rd_req_c, push_c, pop_c, full_c, empty_c, more_c;

    // A held request is not re-sampled while its own ack is showing.
    assign wr_req_c = bus.cpu_req &  bus.cpu_write & ~cpu_ack_q;
    assign rd_req_c = bus.cpu_req & ~bus.cpu_write & ~cpu_ack_q;
    assign full_c   = (count_q == CNT_W'(WBUF_DEPTH));
    assign empty_c  = (count_q == '0);
    assign more_c   = (count_q > CNT_W'(1));
    assign pop_c    = mem_en_q & mem_we_q & bus.mem_ready;
    // A full buffer still accepts on the edge that pops the head.
    assign push_c   = wr_req_c & (~full_c | pop_c);
    assign head_nxt = head_q + PTR_W'(1);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_c) tail_d = tail_q + PTR_W'(1);
        if (pop_c)  head_d = head_nxt;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef MEM_BUS_STORE_FWD_EN
    logic                 fwd_hit_c;
    logic [BITS_DATA-1:0] fwd_data_c;

    // Walk valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) &&
                (wbuf_q[head_q + PTR_W'(k)].addr == bus.cpu_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = wbuf_q[head_q + PTR_W'(k)].data;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push_c) wbuf_q[tail_q] <= {bus.cpu_addr, bus.cpu_wdata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wbuf_full_q  <= 1'b0;
            wbuf_empty_q <= 1'b1;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            wbuf_full_q  <= (count_d == CNT_W'(WBUF_DEPTH));
            wbuf_empty_q <= (count_d == '0);
            cpu_ack_q    <= push_c;

            unique case (state_q)
                ST_IDLE: begin
                    if (rd_req_c) begin
                        // Nothing buffered means no ordering hazard: issue the read at once.
                        if (empty_c) begin
                            mem_en_q   <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= bus.cpu_addr;
                            state_q    <= ST_READ_MEM;
                        end else begin
                            state_q    <= ST_READ_CHK;
                        end
                    end else if (!empty_c) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wbuf_q[head_q].addr;
                        mem_wdata_q <= wbuf_q[head_q].data;
                        state_q     <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (bus.mem_ready) begin
                        if (!rd_req_c && more_c) begin
                            mem_addr_q  <= wbuf_q[head_nxt].addr;
                            mem_wdata_q <= wbuf_q[head_nxt].data;
                        end else begin
                            mem_en_q <= 1'b0;
                            mem_we_q <= 1'b0;
                            state_q  <= rd_req_c ? ST_READ_CHK : ST_IDLE;
                        end
                    end
                end

                ST_READ_CHK: begin
`ifdef MEM_BUS_STORE_FWD_EN
                    if (fwd_hit_c) begin
                        cpu_rdata_q <= fwd_data_c;
                        cpu_ack_q   <= 1'b1;
                        state_q     <= ST_ACK;
                    end else begin
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.cpu_addr;
                        state_q    <= ST_READ_MEM;
                    end
`else
                    // Strict order: drain every buffered write before the read goes out.
                    if (mem_en_q) begin
                        if (bus.mem_ready) begin
                            if (more_c) begin
                                mem_addr_q  <= wbuf_q[head_nxt].addr;
                                mem_wdata_q <= wbuf_q[head_nxt].data;
                            end else begin
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= bus.cpu_addr;
                                state_q    <= ST_READ_MEM;
                            end
                        end
                    end else if (empty_c) begin
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.cpu_addr;
                        state_q    <= ST_READ_MEM;
                    end else begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wbuf_q[head_q].addr;
                        mem_wdata_q <= wbuf_q[head_q].data;
                    end
`endif
                end

                ST_READ_MEM: begin
                    if (bus.mem_ready) begin
                        cpu_rdata_q <= bus.mem_rdata;
                        cpu_ack_q   <= 1'b1;
                        mem_en_q    <= 1'b0;
                        state_q     <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    if (!empty_c) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wbuf_q[head_q].addr;
                        mem_wdata_q <= wbuf_q[head_q].data;
                        state_q     <= ST_DRAIN;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.wbuf_full  = wbuf_full_q;
    assign bus.wbuf_empty = wbuf_empty_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule
